i2c_target: RTL and testbench

- I2C target (slave) sitting directly downstream of the i2c_wrapper controller on the shared scl/sda bus.
- Decodes START/STOP, matches a 7-bit device address and ACKs each byte.
- Write transactions load a register pointer, then write bytes into an internal 2^ADDRWIDTH x DATAWIDTH register file; read transactions return bytes from that file. The pointer auto-increments in both cases.
- Gives the wrapper bench a protocol-checking endpoint and gives the SoC a bus-mapped register bank.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_bus_sync.sv | 40 ++++
 rtl/i2c_target.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } i2c_tgt_state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

  localparam logic [6:0] I2C_DEFAULT_TARGET_ADDR = 7'h2A;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  // Bit 0 is the metastable stage, bit 1 the synchronized level, bit 2 the previous level.
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
  end

  // Idle bus is high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];
  assign sda_sync  =  sda_q[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target with a bus-mapped register file: address match, pointer load,
// auto-incrementing byte writes and reads.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int          DATAWIDTH   = 8,
  parameter int          ADDRWIDTH   = 6,
  parameter logic [6:0]  TARGET_ADDR = I2C_DEFAULT_TARGET_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 busy,
  output logic                 wr_strobe,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic [DATAWIDTH-1:0] wr_data
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH-1:0] PTR_ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};

  logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s, sda_sync_s;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_det_s),
    .stop_det  (stop_det_s),
    .sda_sync  (sda_sync_s)
  );

  i2c_tgt_state_t          state_q, state_d;
  logic [3:0]              bitcnt_q, bitcnt_d;
  logic [DATAWIDTH-2:0]    shift_q, shift_d;
  logic [ADDRWIDTH-1:0]    ptr_q, ptr_d;
  logic                    rw_q, rw_d;
  logic                    sda_oe_q, sda_oe_d;
  logic                    busy_q, busy_d;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [ADDRWIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [DATAWIDTH-1:0]    wr_data_q, wr_data_d;
  logic [DATAWIDTH-1:0]    mem_q [DEPTH];

  logic [DATAWIDTH-1:0]    byte_s;
  logic [DATAWIDTH-1:0]    rd_byte_s;
  logic [2:0]              rd_idx_s;
  logic                    rd_bit_s;

  always_comb begin
    byte_s    = {shift_q, sda_sync_s};
    rd_byte_s = mem_q[ptr_q];
    rd_idx_s  = 3'd7 - bitcnt_q[2:0];
    rd_bit_s  = rd_byte_s[rd_idx_s];
  end

  // Next-state logic; STOP beats START, and both beat any SCL edge seen in the same clk.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (stop_det_s) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      bitcnt_d = 4'd0;
    end else if (start_det_s) begin
      state_d  = ST_ADDR;
      sda_oe_d = 1'b0;
      bitcnt_d = 4'd0;
      shift_d  = {(DATAWIDTH-1){1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end

        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_s) begin
            shift_d  = byte_s[DATAWIDTH-2:0];
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = 4'd0;
              case (state_q)
                ST_ADDR: begin
                  if (byte_s[DATAWIDTH-1:1] == TARGET_ADDR) begin
                    state_d = ST_ADDR_ACK;
                    busy_d  = 1'b1;
                    rw_d    = byte_s[0];
                  end else begin
                    state_d = ST_IGNORE;
                    busy_d  = 1'b0;
                  end
                end
                ST_PTR: begin
                  ptr_d   = byte_s[ADDRWIDTH-1:0];
                  state_d = ST_PTR_ACK;
                end
                ST_WDATA: begin
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = ptr_q;
                  wr_data_d   = byte_s;
                  ptr_d       = ptr_q + PTR_ONE;
                  state_d     = ST_WDATA_ACK;
                end
                default: state_d = ST_IDLE;
              endcase
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end

        // First SCL fall starts the ACK, the fall after the 9th rise ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_q) begin
              sda_oe_d = ~I2C_ACK;
            end else begin
              sda_oe_d = 1'b0;
              bitcnt_d = 4'd0;
              case (state_q)
                ST_ADDR_ACK: begin
                  if (rw_q == I2C_RW_READ) begin
                    state_d  = ST_RDATA;
                    sda_oe_d = ~rd_bit_s;
                  end else begin
                    state_d = ST_PTR;
                  end
                end
                ST_PTR_ACK, ST_WDATA_ACK: state_d = ST_WDATA;
                default:                  state_d = ST_IDLE;
              endcase
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_RDATA: begin
          if (scl_rise_s) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall_s) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = ST_RACK;
            end else begin
              sda_oe_d = ~rd_bit_s;
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_RACK: begin
          if (scl_rise_s) begin
            if (sda_sync_s == I2C_NACK) begin
              state_d  = ST_IGNORE;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end else begin
              ptr_d    = ptr_q + PTR_ONE;
              bitcnt_d = 4'd0;
              state_d  = ST_RDATA;
            end
          end else begin
            state_d = state_q;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 4'd0;
      shift_q     <= {(DATAWIDTH-1){1'b0}};
      ptr_q       <= {ADDRWIDTH{1'b0}};
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= {ADDRWIDTH{1'b0}};
      wr_data_q   <= {DATAWIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register file, written only by completed bus data bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATAWIDTH{1'b0}};
      end
    end else if (wr_strobe_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: table of write transactions plus hand-written
// read-back, pointer-wrap, abort and reset-mid-read sequences.
module tb_i2c_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_w;
  logic       sda_oe;
  logic       busy;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  assign sda_w = sda_m & ~sda_oe;

  i2c_target dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl),
    .sda_in    (sda_w),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int strobe_cnt = 0;
  int oe_cnt     = 0;
  int busy_cnt   = 0;
  logic [5:0] sa_q [$];
  logic [7:0] sd_q [$];

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      sa_q.push_back(wr_addr);
      sd_q.push_back(wr_data);
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy)   busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      wq(Q); sda_m = 1'b1;
      wq(Q); scl = 1'b1;
    end
    wq(Q); sda_m = 1'b0;
    wq(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wq(Q); sda_m = 1'b0;
    wq(Q); scl = 1'b1;
    wq(Q); sda_m = 1'b1;
    wq(Q);
  endtask

  task automatic send_bit(input logic b);
    wq(Q); sda_m = b;
    wq(Q); scl = 1'b1;
    wq(2*Q); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wq(Q); sda_m = 1'b1;
    wq(Q); scl = 1'b1;
    wq(Q); ack = ~sda_w;
    wq(Q); scl = 1'b0;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b, output logic oe_at_ack);
    wq(Q); sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq(2*Q); scl = 1'b1;
      wq(Q); b[i] = sda_w;
      wq(Q); scl = 1'b0;
    end
    wq(Q); sda_m = mack;
    wq(Q); scl = 1'b1;
    wq(Q); oe_at_ack = sda_oe;
    wq(Q); scl = 1'b0;
    wq(2); sda_m = 1'b1;
  endtask

  task automatic read_setup(input logic [7:0] ptr, output logic ok);
    logic a;
    ok = 1'b1;
    bus_start(); send_byte(8'h54, a); ok &= a;
    send_byte(ptr, a); ok &= a;
    bus_start(); send_byte(8'h55, a); ok &= a;
  endtask

  typedef struct {
    logic [7:0] addr_b;
    logic [7:0] ptr_b;
    logic [7:0] data_b;
    logic       exp_ack;
    logic [5:0] exp_wa;
    logic [7:0] exp_wd;
  } wvec_t;

  wvec_t vecs [5];

  initial begin
    logic a0, a1, a2, ok, oe_ack;
    logic [7:0] rb;
    int s0, o0, b0;

    vecs[0] = '{8'h54, 8'h0D, 8'hE5, 1'b1, 6'h0D, 8'hE5};
    vecs[1] = '{8'h60, 8'h0D, 8'hAA, 1'b0, 6'h00, 8'h00};
    vecs[2] = '{8'h54, 8'h20, 8'h5A, 1'b1, 6'h20, 8'h5A};
    vecs[3] = '{8'h54, 8'hC1, 8'h3C, 1'b1, 6'h01, 8'h3C};
    vecs[4] = '{8'h56, 8'h02, 8'h99, 1'b0, 6'h00, 8'h00};

    reset = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wq(4);
    check("reset_sda_oe", sda_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_wr_strobe", wr_strobe, 1'b0);
    check("reset_wr_addr", wr_addr, 6'h00);
    check("reset_wr_data", wr_data, 8'h00);
    reset = 1'b1;
    wq(4);

    for (int v = 0; v < 5; v++) begin
      s0 = strobe_cnt; o0 = oe_cnt; b0 = busy_cnt;
      bus_start();
      send_byte(vecs[v].addr_b, a0);
      send_byte(vecs[v].ptr_b, a1);
      send_byte(vecs[v].data_b, a2);
      bus_stop();
      check($sformatf("v%0d_ack_addr", v), a0, vecs[v].exp_ack);
      check($sformatf("v%0d_ack_ptr", v), a1, vecs[v].exp_ack);
      check($sformatf("v%0d_ack_data", v), a2, vecs[v].exp_ack);
      check($sformatf("v%0d_strobes", v), strobe_cnt - s0, vecs[v].exp_ack ? 1 : 0);
      if (vecs[v].exp_ack && strobe_cnt > s0) begin
        check($sformatf("v%0d_wr_addr", v), sa_q[s0], vecs[v].exp_wa);
        check($sformatf("v%0d_wr_data", v), sd_q[s0], vecs[v].exp_wd);
      end
      check($sformatf("v%0d_oe_activity", v), oe_cnt != o0, vecs[v].exp_ack);
      check($sformatf("v%0d_busy_activity", v), busy_cnt != b0, vecs[v].exp_ack);
      check($sformatf("v%0d_busy_after_stop", v), busy, 1'b0);
    end

    // Read back 0x0D with master NACK.
    read_setup(8'h0D, ok);
    check("rb_setup_ack", ok, 1'b1);
    read_byte(1'b1, rb, oe_ack);
    check("rb_data", rb, 8'hE5);
    check("rb_oe_at_rack", oe_ack, 1'b0);
    wq(4);
    check("rb_busy_after_nack", busy, 1'b0);
    bus_stop();

    // Pointer wrap on write and read.
    s0 = strobe_cnt;
    bus_start();
    send_byte(8'h54, a0); send_byte(8'h3F, a1); send_byte(8'h11, a2);
    ok = a0 & a1 & a2;
    send_byte(8'h22, a0);
    ok &= a0;
    bus_stop();
    check("wrap_wr_acks", ok, 1'b1);
    check("wrap_strobes", strobe_cnt - s0, 2);
    if (strobe_cnt >= s0 + 2) begin
      check("wrap_wa0", sa_q[s0], 6'h3F);
      check("wrap_wd0", sd_q[s0], 8'h11);
      check("wrap_wa1", sa_q[s0+1], 6'h00);
      check("wrap_wd1", sd_q[s0+1], 8'h22);
    end
    read_setup(8'h3F, ok);
    check("wrap_rd_setup_ack", ok, 1'b1);
    read_byte(1'b0, rb, oe_ack);
    check("wrap_rd0", rb, 8'h11);
    read_byte(1'b1, rb, oe_ack);
    check("wrap_rd1", rb, 8'h22);
    bus_stop();

    // Abort: STOP after 4 bits of a data byte, then a normal write.
    s0 = strobe_cnt;
    bus_start();
    send_byte(8'h54, a0); send_byte(8'h05, a1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    wq(2);
    check("abort_acks", a0 & a1, 1'b1);
    check("abort_no_strobe", strobe_cnt - s0, 0);
    check("abort_busy", busy, 1'b0);
    check("abort_sda_oe", sda_oe, 1'b0);
    s0 = strobe_cnt;
    bus_start();
    send_byte(8'h54, a0); send_byte(8'h05, a1); send_byte(8'h77, a2);
    bus_stop();
    check("post_abort_acks", a0 & a1 & a2, 1'b1);
    check("post_abort_strobes", strobe_cnt - s0, 1);
    if (strobe_cnt > s0) begin
      check("post_abort_wa", sa_q[s0], 6'h05);
      check("post_abort_wd", sd_q[s0], 8'h77);
    end

    // Reset while the target drives bit 7 (0) of mem[0x3F] = 0x11.
    read_setup(8'h3F, ok);
    check("rst_setup_ack", ok, 1'b1);
    wq(Q);
    check("rst_pre_sda_oe", sda_oe, 1'b1);
    check("rst_pre_busy", busy, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("rst_async_sda_oe", sda_oe, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    wq(3);
    reset = 1'b1;
    wq(4);
    bus_stop();
    read_setup(8'h3F, ok);
    check("rst_rb_setup_ack", ok, 1'b1);
    read_byte(1'b0, rb, oe_ack);
    check("rst_rb_3f", rb, 8'h00);
    read_byte(1'b1, rb, oe_ack);
    check("rst_rb_00", rb, 8'h00);
    bus_stop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
